// File: rtl/sample_playback_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sample_playback_ctrl_pkg
// Shared definitions for the sample playback controller:
//   - MEM_DEPTH   : depth of the sample ROM being addressed
//   - NB_ADDR_DEF : default address width (log2 of MEM_DEPTH)
//   - NB_DIV_DEF  : default width of the rate divider setting
//   - state_e     : playback FSM state encoding
// -----------------------------------------------------------------------------
package sample_playback_ctrl_pkg;

  localparam int MEM_DEPTH   = 1024;
  localparam int NB_ADDR_DEF = $clog2(MEM_DEPTH);
  localparam int NB_DIV_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sample_playback_ctrl_divider.sv
// -----------------------------------------------------------------------------
// sample_rate_divider
// Loadable down-counter that paces sample offers.
// Ports:
//   i_clock    : clock, rising edge
//   i_reset    : asynchronous active-high reset (count -> 0)
//   i_load     : load i_load_val (has priority over i_enable)
//   i_load_val : value to load
//   i_enable   : decrement by one; holds at zero
//   o_count    : current count
//   o_zero     : count is zero
// -----------------------------------------------------------------------------
module sample_rate_divider
  import sample_playback_ctrl_pkg::*;
#(
  parameter int NB_DIV = NB_DIV_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [NB_DIV-1:0] i_load_val,
  input  logic              i_enable,
  output logic [NB_DIV-1:0] o_count,
  output logic              o_zero
);

  logic [NB_DIV-1:0] count_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= i_load_val;
    end else if (i_enable && (count_q != '0)) begin
      count_q <= count_q - NB_DIV'(1);
    end
  end

  assign o_count = count_q;
  assign o_zero  = (count_q == '0);

endmodule

// File: rtl/sample_playback_ctrl.sv
// -----------------------------------------------------------------------------
// sample_playback_ctrl
// Sequences read addresses into the sample ROM with start/stop/pause control,
// a programmable window (start address, length-1), one-shot or loop playback
// and a sample-rate divider. Each address is offered with valid/ready.
// Ports:
//   i_clock, i_reset : clock (rising) and asynchronous active-high reset
//   i_start, i_stop  : one-cycle start (IDLE/DONE only) and abort requests
//   i_pause          : level, freezes playback while high
//   i_loop, i_start_addr, i_length, i_rate_div : config, latched at start
//   i_ready          : downstream accepts the offered address
//   o_addr, o_valid  : offered ROM address and its valid flag
//   o_busy           : state is RUN or HOLD
//   o_done           : one-cycle pulse at one-shot completion
//   o_wrap           : one-cycle pulse when a loop restarts
// -----------------------------------------------------------------------------
module sample_playback_ctrl
  import sample_playback_ctrl_pkg::*;
#(
  parameter int NB_ADDR = NB_ADDR_DEF,
  parameter int NB_DIV  = NB_DIV_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_pause,
  input  logic               i_loop,
  input  logic [NB_ADDR-1:0] i_start_addr,
  input  logic [NB_ADDR-1:0] i_length,
  input  logic [NB_DIV-1:0]  i_rate_div,
  input  logic               i_ready,
  output logic [NB_ADDR-1:0] o_addr,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_wrap
);

  state_e             state_q;
  logic [NB_ADDR-1:0] addr_q, remaining_q, start_addr_q, length_q;
  logic [NB_DIV-1:0]  rate_div_q;
  logic               loop_q, valid_q, busy_q, done_q, wrap_q;

  logic               accept, start_ok, run_accept, last_sample;
  logic               rate_load, rate_en, rate_zero, rate_expire;
  logic [NB_DIV-1:0]  rate_load_val, rate_count;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    accept        = 1'b0;
    start_ok      = 1'b0;
    run_accept    = 1'b0;
    last_sample   = 1'b0;
    rate_load     = 1'b0;
    rate_load_val = '0;
    rate_en       = 1'b0;
    rate_expire   = 1'b0;

    accept      = valid_q & i_ready;
    last_sample = (remaining_q == '0);
    // Stop wins over a simultaneous start.
    start_ok    = i_start & ~i_stop &
                  ((state_q == ST_IDLE) | (state_q == ST_DONE));
    run_accept  = (state_q == ST_RUN) & accept & ~i_stop;

    rate_load     = start_ok | run_accept;
    rate_load_val = start_ok ? '0 : rate_div_q;
    // Counting only happens while waiting to offer; HOLD freezes it.
    rate_en       = (state_q == ST_RUN) & ~valid_q & ~i_pause & ~i_stop;
    // Valid rises on the edge where the counter reaches zero, giving an
    // offer spacing of rate_div+1 cycles.
    rate_expire   = rate_zero | (rate_count == NB_DIV'(1));
  end

  sample_rate_divider #(
    .NB_DIV (NB_DIV)
  ) u_rate_div (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (rate_load),
    .i_load_val (rate_load_val),
    .i_enable   (rate_en),
    .o_count    (rate_count),
    .o_zero     (rate_zero)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      start_addr_q <= '0;
      length_q     <= '0;
      rate_div_q   <= '0;
      loop_q       <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            start_addr_q <= i_start_addr;
            length_q     <= i_length;
            rate_div_q   <= i_rate_div;
            loop_q       <= i_loop;
            addr_q       <= i_start_addr;
            remaining_q  <= i_length;
            // First sample is offered right away.
            valid_q      <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_RUN;
          end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (i_stop) begin
            // Only permitted handshake abort: drop valid even if unaccepted.
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (accept) begin
            if (last_sample && !loop_q) begin
              addr_q  <= addr_q + NB_ADDR'(1);
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              if (last_sample) begin
                addr_q      <= start_addr_q;
                remaining_q <= length_q;
                wrap_q      <= 1'b1;
              end else begin
                addr_q      <= addr_q + NB_ADDR'(1);
                remaining_q <= remaining_q - NB_ADDR'(1);
              end
              if (i_pause) begin
                valid_q <= 1'b0;
                state_q <= ST_HOLD;
              end else begin
                // Back-to-back offers only at rate_div == 0.
                valid_q <= (rate_div_q == '0);
              end
            end
          end else if (!valid_q) begin
            if (i_pause) begin
              state_q <= ST_HOLD;
            end else if (rate_expire) begin
              valid_q <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (i_stop) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!i_pause) begin
            state_q <= ST_RUN;
          end
        end

        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_addr  = addr_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_sample_playback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sample_playback_ctrl
// Directed per-cycle vectors (inputs applied before a rising edge, outputs
// compared on the following falling edge) plus hand-written reset sequences.
// -----------------------------------------------------------------------------
module tb_sample_playback_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, pause, loop, ready;
  logic [9:0] start_addr, length;
  logic [7:0] rate_div;
  logic [9:0] addr;
  logic       valid, busy, done, wrap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sample_playback_ctrl dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_pause      (pause),
    .i_loop       (loop),
    .i_start_addr (start_addr),
    .i_length     (length),
    .i_rate_div   (rate_div),
    .i_ready      (ready),
    .o_addr       (addr),
    .o_valid      (valid),
    .o_busy       (busy),
    .o_done       (done),
    .o_wrap       (wrap)
  );

  typedef struct {
    logic       start, stop, pause, ready, loop;
    logic [9:0] sa, len;
    logic [7:0] rd;
    logic       ev;
    logic [9:0] ea;
    logic       eb, ed, ew;
  } vec_t;

  vec_t       tbl[$];
  logic       cur_loop;
  logic [9:0] cur_sa, cur_len;
  logic [7:0] cur_rd;

  task automatic set_cfg(input logic [9:0] sa, input logic [9:0] len,
                         input logic [7:0] rd, input logic lp);
    cur_sa = sa; cur_len = len; cur_rd = rd; cur_loop = lp;
  endtask

  // One cycle: st sp pa rdy | expected valid addr busy done wrap
  task automatic add(input logic st, input logic sp, input logic pa,
                     input logic rdy, input logic ev, input int ea,
                     input logic eb, input logic ed, input logic ew);
    vec_t v;
    v.start = st; v.stop = sp; v.pause = pa; v.ready = rdy; v.loop = cur_loop;
    v.sa = cur_sa; v.len = cur_len; v.rd = cur_rd;
    v.ev = ev; v.ea = 10'(ea); v.eb = eb; v.ed = ed; v.ew = ew;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name, input int idx);
    check({name, ".valid"}, idx, 32'(valid), 32'd0);
    check({name, ".addr"},  idx, 32'(addr),  32'd0);
    check({name, ".busy"},  idx, 32'(busy),  32'd0);
    check({name, ".done"},  idx, 32'(done),  32'd0);
    check({name, ".wrap"},  idx, 32'(wrap),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 0; stop = 0; pause = 0; loop = 0; ready = 0;
    start_addr = '0; length = '0; rate_div = '0;

    // ---------------- table ----------------
    // One-shot, 4 samples from 0, no spacing.
    set_cfg(10'd0, 10'd3, 8'd0, 1'b0);
    add(1,0,0,1, 1,0,1,0,0);
    add(0,0,0,1, 1,1,1,0,0);
    add(0,0,0,1, 1,2,1,0,0);
    add(0,0,0,1, 1,3,1,0,0);
    add(0,0,0,1, 0,0,0,1,0);   // last accepted -> DONE pulse, busy falls
    add(0,0,0,1, 0,0,0,0,0);   // back to IDLE

    // Loop across the top of memory, offers every 3 cycles.
    set_cfg(10'd1022, 10'd3, 8'd2, 1'b1);
    add(1,0,0,1, 1,1022,1,0,0);
    add(0,0,0,1, 0,0,1,0,0);
    add(0,0,0,1, 0,0,1,0,0);
    add(0,0,0,1, 1,1023,1,0,0);
    add(0,0,0,1, 0,0,1,0,0);
    add(0,0,0,1, 0,0,1,0,0);
    add(0,0,0,1, 1,0,1,0,0);
    add(0,0,0,1, 0,0,1,0,0);
    add(0,0,0,1, 0,0,1,0,0);
    add(0,0,0,1, 1,1,1,0,0);
    add(0,0,0,1, 0,0,1,0,1);   // accept of addr 1 -> wrap pulse
    add(0,0,0,1, 0,0,1,0,0);
    add(0,0,0,1, 1,1022,1,0,0);
    add(0,0,0,1, 0,0,1,0,0);
    add(0,1,0,1, 0,0,0,0,0);   // stop

    // Backpressure at addr 2 for 5 cycles.
    set_cfg(10'd0, 10'd7, 8'd0, 1'b0);
    add(1,0,0,1, 1,0,1,0,0);
    add(0,0,0,1, 1,1,1,0,0);
    add(0,0,0,1, 1,2,1,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0, 1,2,1,0,0);
    add(0,0,0,1, 1,3,1,0,0);
    add(0,1,0,1, 0,0,0,0,0);

    // Pause while offering and stalled; start during HOLD is ignored.
    set_cfg(10'd10, 10'd7, 8'd1, 1'b0);
    add(1,0,0,0, 1,10,1,0,0);
    add(0,0,1,0, 1,10,1,0,0);
    add(0,0,1,0, 1,10,1,0,0);
    add(0,0,1,1, 0,0,1,0,0);   // accept while paused -> HOLD
    set_cfg(10'd500, 10'd7, 8'd1, 1'b0);
    add(1,0,1,1, 0,0,1,0,0);
    add(0,0,0,1, 0,0,1,0,0);   // release -> RUN
    add(0,0,0,0, 1,11,1,0,0);  // next address after rate_div+1 cycles
    add(0,1,0,0, 0,0,0,0,0);

    // Start and stop together mid-RUN: stop wins, then restart elsewhere.
    set_cfg(10'd20, 10'd7, 8'd0, 1'b0);
    add(1,0,0,1, 1,20,1,0,0);
    add(0,0,0,1, 1,21,1,0,0);
    set_cfg(10'd100, 10'd7, 8'd0, 1'b0);
    add(1,1,0,1, 0,0,0,0,0);
    add(0,0,0,1, 0,0,0,0,0);
    add(1,0,0,1, 1,100,1,0,0);
    add(0,0,0,1, 1,101,1,0,0);
    add(0,1,0,1, 0,0,0,0,0);

    // ---------------- reset state ----------------
    @(negedge clk);
    check_idle_outputs("reset", 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset", 0);

    // ---------------- table application ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; stop = tbl[i].stop; pause = tbl[i].pause;
      ready = tbl[i].ready; loop = tbl[i].loop;
      start_addr = tbl[i].sa; length = tbl[i].len; rate_div = tbl[i].rd;
      @(posedge clk);
      @(negedge clk);
      check("valid", i, 32'(valid), 32'(tbl[i].ev));
      if (tbl[i].ev) check("addr", i, 32'(addr), 32'(tbl[i].ea));
      check("busy", i, 32'(busy), 32'(tbl[i].eb));
      check("done", i, 32'(done), 32'(tbl[i].ed));
      check("wrap", i, 32'(wrap), 32'(tbl[i].ew));
    end
    start = 0; stop = 0; pause = 0;

    // ---------------- asynchronous reset mid-RUN at addr 5 ----------------
    start_addr = 10'd0; length = 10'd15; rate_div = 8'd0; loop = 0; ready = 1;
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    check("mid_run.addr",  0, 32'(addr),  32'd5);
    check("mid_run.valid", 0, 32'(valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_reset", 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_reset.valid", i, 32'(valid), 32'd0);
      check("after_reset.busy",  i, 32'(busy),  32'd0);
    end
    start_addr = 10'd7; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    check("restart.valid", 0, 32'(valid), 32'd1);
    check("restart.addr",  0, 32'(addr),  32'd7);
    check("restart.busy",  0, 32'(busy),  32'd1);
    stop = 1;
    @(negedge clk);
    stop = 0;
    check("restart_stop.busy", 0, 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_playback_ctrl.md
Name: sample_playback_ctrl

Overview:
- Sequences read addresses into the 1024-entry sample ROM that feeds the FIR chain.
- Replaces the free-running address counter with start/stop/pause control and a programmable window (start address, length).
- Supports one-shot or loop playback, and a programmable sample-rate divider.
- Delivers each address with a valid/ready handshake so the downstream FIR can stall playback.

Parameters:
- NB_ADDR, 10, sample memory address width (memory depth 2^NB_ADDR).
- NB_DIV, 8, width of the rate divider setting.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle start request; accepted only in IDLE or DONE.
- i_stop  in  1  one-cycle abort request.
- i_pause  in  1  level; freezes playback while high.
- i_loop  in  1  loop mode, sampled at accepted start.
- i_start_addr  in  NB_ADDR  first sample address, sampled at start.
- i_length  in  NB_ADDR  window length minus one (0 -> 1 sample, 1023 -> 1024 samples), sampled at start.
- i_rate_div  in  NB_DIV  minimum spacing between sample offers, in cycles, is i_rate_div+1; sampled at start.
- i_ready  in  1  downstream accepts the current address.
- o_addr  out  NB_ADDR  sample ROM read address.
- o_valid  out  1  o_addr is offered.
- o_busy  out  1  high in RUN or HOLD.
- o_done  out  1  one-cycle pulse at one-shot completion.
- o_wrap  out  1  one-cycle pulse when a loop restarts.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Reset is asynchronous and may arrive mid-playback; it returns to IDLE immediately and drops o_valid.
- States are IDLE, RUN, HOLD and DONE. All outputs are registered.
- Transitions:
  - IDLE/DONE -> RUN on i_start. Config is latched, o_addr <= i_start_addr, remaining <= i_length, rate counter <= 0.
  - RUN -> HOLD when i_pause=1 and o_valid=0, or on the accept cycle if i_pause=1.
  - HOLD -> RUN when i_pause=0. The rate counter is frozen in HOLD.
  - RUN/HOLD -> IDLE on i_stop, next cycle. o_valid drops even if unaccepted; this is the only permitted handshake abort. o_done is not pulsed.
  - RUN -> DONE on accept of the last sample with loop=0. DONE lasts exactly one cycle (o_done=1), then IDLE unless i_start is present in DONE.
- Simultaneous i_start and i_stop: stop wins, start is ignored.
- i_start in RUN or HOLD is ignored.
- Rate counter:
  - While in RUN with o_valid=0, the counter decrements each cycle.
  - o_valid rises the cycle after the counter reaches 0, or the cycle after entering RUN for the first sample (latency 1 from i_start).
- Handshake:
  - Accept = o_valid & i_ready.
  - Once o_valid is high, it and o_addr stay stable until accept. i_pause does not drop o_valid.
  - On accept, the rate counter <= rate_div. o_valid drops unless rate_div=0 and another sample remains; back-to-back accepts are allowed at rate_div=0.
- Address and count arithmetic:
  - On accept, o_addr <= o_addr+1 modulo 2^NB_ADDR, so a window crossing 1023 wraps to 0.
  - Remaining decrements by 1. The sample offered with remaining=0 is the last.
- Loop restart: on accept of the last sample with loop=1, o_addr <= latched start_addr, remaining <= latched length, o_wrap=1 for one cycle, and state stays RUN.
- o_busy = (state==RUN)|(state==HOLD).

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, RUN=1, HOLD=2, DONE=3).
  - default widths NB_ADDR=10, NB_DIV=8.
  - MEM_DEPTH=1024.
- One sub-module, sample_rate_divider: a loadable down-counter with load and enable inputs and a zero flag.
- Top level holds the FSM, the address/remaining counters and the handshake.

Test Plan:
- start_addr=0, length=3, rate_div=0, loop=0, i_ready=1:
  - o_valid high cycles 1-4 after start, o_addr 0,1,2,3.
  - o_done pulses the cycle after addr 3 is accepted; o_busy falls with it.
- start_addr=1022, length=3, rate_div=2, loop=1, i_ready=1:
  - addresses 1022,1023,0,1,1022,...
  - valid spaced 3 cycles apart; o_wrap pulses at the accept of addr 1.
- Backpressure, rate_div=0, i_ready low for 5 cycles at addr 2: o_valid stays high with o_addr=2 for all 5 cycles, then advances to 3 after accept.
- i_pause raised while o_valid=1 and i_ready=0: valid is held until accept, then HOLD with o_valid=0 and o_busy=1. Release resumes at the next address after rate_div+1 cycles.
- i_stop and i_start together mid-RUN: next cycle IDLE, o_valid=0, no o_done. A later i_start restarts from the newly sampled i_start_addr.
- Reset asserted mid-RUN at addr 5: all outputs 0 immediately, asynchronously. After release, the block stays IDLE with no valid until i_start.
